// File: rtl/cpu6502_timer_pkg.sv
// Shared register map and field positions for the cpu6502 interval timer.
package cpu6502_timer_pkg;

    localparam logic [1:0] REG_CNT_LO = 2'd0;
    localparam logic [1:0] REG_CNT_HI = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STAT   = 2'd3;

    localparam int CTRL_RUN_BIT   = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_IRQEN_BIT = 2;
    localparam int CTRL_RSVD_BIT  = 3;
    localparam int CTRL_PRE_LSB   = 4;

    localparam int STAT_IF_BIT = 7;

    function automatic logic [7:0] stat_byte(input logic flag, input logic run);
        logic [7:0] v;
        v              = 8'h00;
        v[STAT_IF_BIT] = flag;
        v[0]           = run;
        return v;
    endfunction

endpackage

// File: rtl/cpu6502_timer_prescaler.sv
// Prescaler for the interval timer: emits one tick every PRE+1 clocks while running.
module cpu6502_timer_prescaler (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_run,
    input  logic       i_clr,
    input  logic [3:0] i_pre,
    output logic       o_tick
);

    logic [3:0] r_pre_cnt;

    assign o_tick = i_run & (r_pre_cnt == i_pre);

    // Prescale counter: held at zero while stopped, restarted on reload or tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre_cnt <= 4'd0;
        end else if (!i_run || i_clr || o_tick) begin
            r_pre_cnt <= 4'd0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/cpu6502_timer.sv
// Memory-mapped 16-bit interval timer for the cpu6502 bus; bus side effects
// are committed once per bus cycle, on the clk edge that ends phi2.
module cpu6502_timer
    import cpu6502_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hD000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        rw,
    input  logic        clk2,
    output logic [7:0]  rdata,
    output logic        sel,
    output logic        irq
);

    logic        r_clk2_q;
    logic [15:0] r_cnt;
    logic [15:0] r_latch;
    logic [7:0]  r_hi_shadow;
    logic [7:0]  r_ctrl;
    logic        r_irq_flag;

    logic        w_sel;
    logic [1:0]  w_off;
    logic        w_commit;
    logic        w_wr;
    logic        w_rd;
    logic        w_hi_wr;
    logic        w_ctrl_wr;
    logic        w_stat_clr;
    logic        w_tick;
    logic        w_underflow;

    assign w_sel       = (addr[15:2] == BASE_ADDR[15:2]);
    assign w_off       = addr[1:0];
    assign w_commit    = r_clk2_q & ~clk2 & w_sel;
    assign w_wr        = w_commit & ~rw;
    assign w_rd        = w_commit & rw;
    assign w_hi_wr     = w_wr & (w_off == REG_CNT_HI);
    assign w_ctrl_wr   = w_wr & (w_off == REG_CTRL);
    assign w_stat_clr  = (w_rd & (w_off == REG_STAT)) |
                         (w_wr & (w_off == REG_STAT) & wdata[STAT_IF_BIT]);
    assign w_underflow = w_tick & (r_cnt == 16'd0);

    assign sel = w_sel;
    assign irq = r_irq_flag & r_ctrl[CTRL_IRQEN_BIT];

    cpu6502_timer_prescaler u_prescaler (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_run   (r_ctrl[CTRL_RUN_BIT]),
        .i_clr   (w_hi_wr),
        .i_pre   (r_ctrl[CTRL_PRE_LSB +: 4]),
        .o_tick  (w_tick)
    );

    // phi2 history for detecting the end of the bus cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk2_q <= 1'b0;
        end else begin
            r_clk2_q <= clk2;
        end
    end

    // Reload latch, written byte-wise from the CNT_LO/CNT_HI addresses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_latch <= 16'h0000;
        end else if (w_wr && (w_off == REG_CNT_LO)) begin
            r_latch[7:0] <= wdata;
        end else if (w_hi_wr) begin
            r_latch[15:8] <= wdata;
        end
    end

    // Down-counter; a CNT_HI write overrides any tick on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 16'h0000;
        end else if (w_hi_wr) begin
            r_cnt <= {wdata, r_latch[7:0]};
        end else if (w_tick) begin
            if (r_cnt != 16'd0) begin
                r_cnt <= r_cnt - 16'd1;
            end else if (r_ctrl[CTRL_CONT_BIT]) begin
                r_cnt <= r_latch;
            end
        end
    end

    // Control register; one-shot underflow stops the timer, CNT_HI write starts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl <= 8'h00;
        end else if (w_ctrl_wr) begin
            r_ctrl                <= wdata;
            r_ctrl[CTRL_RSVD_BIT] <= 1'b0;
        end else if (w_hi_wr) begin
            r_ctrl[CTRL_RUN_BIT] <= 1'b1;
        end else if (w_underflow && !r_ctrl[CTRL_CONT_BIT]) begin
            r_ctrl[CTRL_RUN_BIT] <= 1'b0;
        end
    end

    // Interrupt flag: reload clears it, underflow beats an acknowledge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_flag <= 1'b0;
        end else if (w_hi_wr) begin
            r_irq_flag <= 1'b0;
        end else if (w_underflow) begin
            r_irq_flag <= 1'b1;
        end else if (w_stat_clr) begin
            r_irq_flag <= 1'b0;
        end
    end

    // High-byte snapshot taken when the low byte is read, for coherent 16-bit reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi_shadow <= 8'h00;
        end else if (w_rd && (w_off == REG_CNT_LO)) begin
            r_hi_shadow <= r_cnt[15:8];
        end
    end

    // Read mux back to the CPU data-in path.
    always_comb begin
        rdata = 8'h00;
        if (w_sel) begin
            case (w_off)
                REG_CNT_LO: rdata = r_cnt[7:0];
                REG_CNT_HI: rdata = r_hi_shadow;
                REG_CTRL:   rdata = r_ctrl;
                REG_STAT:   rdata = stat_byte(r_irq_flag, r_ctrl[CTRL_RUN_BIT]);
                default:    rdata = 8'h00;
            endcase
        end else begin
            rdata = 8'h00;
        end
    end

endmodule

// File: tb/tb_cpu6502_timer.sv
// Scoreboard bench for cpu6502_timer: stimulus queues expected values,
// monitors compare them when a read commits or a probe is requested.
module tb_cpu6502_timer;

    localparam logic [15:0] BASE = 16'hD000;
    localparam logic [1:0]  LO = 2'd0, HI = 2'd1, CT = 2'd2, ST = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rw;
    logic        clk2;
    logic [7:0]  rdata;
    logic        sel;
    logic        irq;

    typedef struct { string name; logic [7:0] exp; } rd_t;
    typedef struct { string name; int kind; logic [7:0] exp; } pr_t;

    rd_t  q_rd[$];
    pr_t  q_pr[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic clk2_prev = 1'b0;
    event ev_probe;

    always #5 clk = ~clk;

    cpu6502_timer #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .rw    (rw),
        .clk2  (clk2),
        .rdata (rdata),
        .sel   (sel),
        .irq   (irq)
    );

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        clk2_prev <= clk2;
    end

    // Read monitor: a read commits on the coming edge; rdata is checked just before it.
    always @(negedge clk) begin
        rd_t e;
        if (reset && sel && rw && clk2_prev && !clk2) begin
            n_vec++;
            if (q_rd.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_read addr=%h got=%h", addr, rdata);
            end else begin
                e = q_rd.pop_front();
                if (rdata !== e.exp) begin
                    n_err++;
                    $display("FAIL %s got=%h want=%h", e.name, rdata, e.exp);
                end
            end
        end
    end

    // Probe monitor: kind 0 = irq, 1 = rdata, 2 = sel.
    initial begin
        pr_t        p;
        logic [7:0] act;
        forever begin
            @(ev_probe);
            while (q_pr.size() > 0) begin
                p = q_pr.pop_front();
                case (p.kind)
                    0:       act = {7'b0, irq};
                    1:       act = rdata;
                    default: act = {7'b0, sel};
                endcase
                n_vec++;
                if (act !== p.exp) begin
                    n_err++;
                    $display("FAIL %s got=%h want=%h t=%0t", p.name, act, p.exp, $time);
                end
            end
        end
    end

    task automatic probe(input string nm, input int kind, input logic [7:0] exp);
        pr_t p;
        p.name = nm; p.kind = kind; p.exp = exp;
        q_pr.push_back(p);
        ->ev_probe;
        #1;
    endtask

    // One bus cycle: phi2 high for a clock, low for a clock; commits on the second edge.
    task automatic bus(input logic [1:0] off, input logic r, input logic [7:0] d);
        addr  = {BASE[15:2], off};
        rw    = r;
        wdata = d;
        clk2  = 1'b1;
        @(posedge clk); #1;
        clk2  = 1'b0;
        @(posedge clk); #1;
        addr  = 16'h0000;
        rw    = 1'b1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] d);
        bus(off, 1'b0, d);
    endtask

    task automatic rd(input logic [1:0] off, input string nm, input logic [7:0] exp);
        rd_t e;
        e.name = nm; e.exp = exp;
        q_rd.push_back(e);
        bus(off, 1'b1, 8'h00);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int u;
        reset = 1'b0; clk2 = 1'b0; addr = 16'h0000; rw = 1'b1; wdata = 8'h00;
        #12;
        probe("reset_irq", 0, 8'h00);
        probe("reset_rdata_unsel", 1, 8'h00);
        probe("reset_sel_unsel", 2, 8'h00);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        rd(LO, "reset_cnt_lo", 8'h00);
        rd(HI, "reset_cnt_hi", 8'h00);
        rd(CT, "reset_ctrl",   8'h00);
        rd(ST, "reset_stat",   8'h00);

        // One-shot, PRE=0, count 3: flag rises 4 clocks after the CNT_HI commit.
        wr(CT, 8'h04); wr(LO, 8'h03); wr(HI, 8'h00);
        c = cyc;
        wait_to(c + 3); probe("oneshot_irq_early", 0, 8'h00);
        wait_to(c + 4); probe("oneshot_irq_rise", 0, 8'h01);
        rd(ST, "oneshot_stat", 8'h80);
        probe("oneshot_irq_drop", 0, 8'h00);
        wait_to(c + 20); probe("oneshot_stays_idle", 0, 8'h00);
        rd(CT, "oneshot_ctrl_stopped", 8'h04);

        // Coherent read: cnt=0x0101 drops to 0x0100 by the CNT_LO read commit.
        wr(CT, 8'h02); wr(LO, 8'h01); wr(HI, 8'h01);
        rd(LO, "coherent_lo", 8'h00);
        repeat (5) @(posedge clk);
        #1;
        rd(HI, "coherent_hi_shadow", 8'h01);
        wr(CT, 8'h00);

        // Continuous, PRE=3, latch=2: underflow every 12 clocks.
        wr(CT, 8'h36); wr(LO, 8'h02); wr(HI, 8'h00);
        c = cyc;
        u = c + 12;
        for (int k = 0; k < 3; k++) begin
            wait_to(u - 1); probe($sformatf("cont_irq_low_%0d", k), 0, 8'h00);
            wait_to(u);     probe($sformatf("cont_irq_high_%0d", k), 0, 8'h01);
            wr(ST, 8'h80);
            probe($sformatf("cont_irq_cleared_%0d", k), 0, 8'h00);
            u = u + 12;
        end

        // STAT read commit on the underflow edge: set wins.
        wait_to(u - 2);
        rd(ST, "coll_stat_read", 8'h01);
        probe("coll_set_wins", 0, 8'h01);
        wr(ST, 8'h80);
        u = u + 12;

        // CNT_HI write on the underflow edge: write wins, cnt=0x0105.
        wait_to(u - 4);
        wr(LO, 8'h05); wr(HI, 8'h01);
        probe("coll_hi_irq", 0, 8'h00);
        rd(LO, "coll_hi_cnt_lo", 8'h05);
        rd(HI, "coll_hi_cnt_hi", 8'h01);

        // Reset mid-count right after a reload to cnt=5.
        wr(LO, 8'h05); wr(HI, 8'h00);
        c = cyc;
        wait_to(c + 23); probe("midrst_irq_before", 0, 8'h00);
        wait_to(c + 24); probe("midrst_irq_set", 0, 8'h01);
        reset = 1'b0;
        #1;
        probe("midrst_irq_async", 0, 8'h00);
        probe("midrst_rdata_unsel", 1, 8'h00);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            repeat (10) @(posedge clk);
            #1;
            probe($sformatf("postrst_irq_%0d", i), 0, 8'h00);
        end
        rd(LO, "postrst_cnt_lo", 8'h00);
        rd(HI, "postrst_cnt_hi", 8'h00);
        rd(CT, "postrst_ctrl",   8'h00);
        rd(ST, "postrst_stat",   8'h00);

        repeat (2) @(posedge clk);
        while (q_rd.size() > 0) begin
            rd_t e;
            e = q_rd.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s never_committed want=%h", e.name, e.exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu6502_timer.md
Name: cpu6502_timer

Overview:
- Memory-mapped 16-bit interval timer that sits on the cpu6502 bus, beside the ROM.
- Decodes addr/rw/odata from the CPU and returns read data for the CPU's idata mux.
- Drives the CPU irq input.
- Gives the 6502 a periodic or one-shot interrupt source with a programmable prescaler.

Parameters:
- BASE_ADDR, 16'hD000, base of the 4-byte register window; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock, same clock as cpu6502.
- reset  input  1  asynchronous, active-low reset.
- addr  input  16  CPU address bus.
- wdata  input  8  CPU odata.
- rw  input  1  CPU rw: 1 = read, 0 = write.
- clk2  input  1  CPU phi2 phase output.
- rdata  output  8  register read data; valid while sel=1.
- sel  output  1  combinational: addr[15:2] == BASE_ADDR[15:2]; bus mux selects rdata over ROM.
- irq  output  1  active-high level: irq_flag & ctrl[2].

Behaviour:
- Bus commit point
  - clk2 is registered into clk2_q.
  - commit = clk2_q & ~clk2 & sel, i.e. the clk edge at the end of phi2. This gives exactly one commit per bus cycle.
  - Register writes and read side effects happen only on a commit.
- Registers (offset = addr[1:0])
  - 0 CNT_LO. Read: cnt[7:0]. A read commit copies cnt[15:8] into hi_shadow. Write: latch[7:0].
  - 1 CNT_HI. Read: hi_shadow. Write: latch[15:8]; cnt <= {wdata, latch[7:0]}; pre_cnt <= 0; irq_flag <= 0; ctrl[0] <= 1 (start).
  - 2 CTRL. Read/write.
    - bit0: run.
    - bit1: continuous (1) / one-shot (0).
    - bit2: IRQ enable.
    - bit3: reserved; reads 0.
    - bits7:4: PRE.
  - 3 STAT.
    - Read: {irq_flag, 6'b0, ctrl[0]}. A read commit clears irq_flag.
    - Write: wdata[7]=1 clears irq_flag; other bits ignored.
- rdata is combinational from addr[1:0] and is 8'h00 when sel=0.
- Prescaler
  - While ctrl[0]=1, 4-bit pre_cnt increments each clk.
  - tick = (pre_cnt == PRE); on tick, pre_cnt <= 0.
  - Tick period is PRE+1 clk cycles.
  - While ctrl[0]=0, pre_cnt is held at 0.
- Counter, on tick
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0 (underflow): irq_flag <= 1.
    - Continuous mode: cnt <= latch.
    - One-shot mode: ctrl[0] <= 0, cnt stays 0.
  - Underflow period is (latch+1)*(PRE+1) clk cycles.
- Reset
  - Asynchronous and immediate.
  - cnt, latch, hi_shadow, ctrl, pre_cnt, irq_flag and clk2_q all clear to 0.
  - Outputs after reset: irq=0, rdata=0 when not selected.
  - A reset mid-count aborts the count; no flag is left pending.
- Simultaneous events
  - Underflow and STAT read commit on the same edge: irq_flag ends set (set wins).
  - Underflow and CNT_HI write on the same edge: the write wins; cnt loads the new value and irq_flag = 0.
  - CTRL write clearing bit0 on a tick edge: the tick is still applied on that edge, and counting stops afterwards.
  - latch=0 in continuous mode: underflow on every tick; irq_flag stays set.
  - A write with clk2 never falling has no effect.
- Width rules
  - All arithmetic is 16-bit unsigned.
  - Wrap below 0 never occurs; 0 underflows to a reload or a stop.

Decomposition:
- Shared package cpu6502_timer_pkg holds:
  - register offsets REG_CNT_LO=0, REG_CNT_HI=1, REG_CTRL=2, REG_STAT=3;
  - CTRL bit indices;
  - STAT_IF_BIT=7.
- One natural sub-module, cpu6502_timer_prescaler: pre_cnt plus tick generation, with inputs run and PRE and output tick.
- Register file and counter stay in the top module.

Test Plan:
- Reset values: hold reset=0, then release. Expect irq=0, and reads of all 4 offsets return 8'h00.
- One-shot underflow:
  - Write CTRL=8'h04 (IRQ enable, one-shot, PRE=0), CNT_LO=8'h03, CNT_HI=8'h00.
  - Expect irq to rise 4 clk after the CNT_HI commit.
  - STAT then reads 8'h80 (run bit=0).
  - That STAT read commit drops irq on the next clk.
- Continuous with prescaler:
  - Write CTRL=8'h36 (PRE=3, continuous, IRQ enable) and latch=16'h0002.
  - Expect underflows every 12 clk.
  - Clear the flag via a STAT write of 8'h80 after each underflow; irq re-asserts 12 clk after each previous underflow.
- Coherent 16-bit read:
  - Load cnt=16'h0100 with PRE=0.
  - Read CNT_LO (returns 8'h00 at its commit edge), wait 5 clk, then read CNT_HI.
  - Expect 8'h01 (the shadow), not the live high byte 8'h00.
- Collisions:
  - Schedule a STAT read commit on the underflow edge: irq stays 1.
  - Schedule a CNT_HI write on the underflow edge: irq=0 and cnt = the newly written value.
- Reset mid-count:
  - Assert reset while cnt=16'h0005 in continuous mode.
  - Expect irq=0 immediately, and no irq for 100 clk after release.
